// File: rtl/des40_ctrl_pkg.sv
// rtl/des40_ctrl_pkg.sv - shared types and widths for the des40_ctrl frame-sync deserializer
package des40_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  localparam int BIT_CNT_W  = 3;
  localparam int BYTE_CNT_W = 8;
  localparam int MISS_CNT_W = 4;
  localparam int ERR_CNT_W  = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/des40_ctrl_if.sv
// rtl/des40_ctrl_if.sv - serial bit input and byte output handshake bundle for des40_ctrl
interface des40_ctrl_if;

  logic       enable;
  logic       data_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_start;
  logic       frame_end;

  modport master (
    output enable, data_in, byte_ready,
    input  byte_out, byte_valid, frame_start, frame_end
  );

  modport slave (
    input  enable, data_in, byte_ready,
    output byte_out, byte_valid, frame_start, frame_end
  );

endinterface

// File: rtl/des40_ctrl_shift.sv
// rtl/des40_ctrl_shift.sv - LSB-first 8-bit shifter with bit counter and "8 bits seen" flag
module des40_ctrl_shift
  import des40_ctrl_pkg::*;
(
  input  logic       clock_40,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       data_in,
  output logic [7:0] shift_next,
  output logic       byte_done,
  output logic       full
);

  logic [7:0]           shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Post-shift view lets the FSM act on the byte in the same cycle its last bit arrives.
  assign shift_next = {data_in, shift_q[7:1]};
  assign byte_done  = shift_en && (bit_cnt == '1);

  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
    end else if (clear) begin
      shift_q <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
    end else if (shift_en) begin
      shift_q <= shift_next;
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (bit_cnt == '1) full <= 1'b1;
    end
  end

endmodule

// File: rtl/des40_ctrl.sv
// rtl/des40_ctrl.sv - serial frame-sync deserializer: hunt, payload, sync check and byte handshake
// Optional DES40_CTRL_ERRCNT_EN builds the saturating sync_err_cnt; otherwise it reads 8'h00.
module des40_ctrl
  import des40_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
  parameter int         FRAME_BYTES = 16,
  parameter int         LOCK_MISSES = 3
) (
  input  logic         clock_40,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  des40_ctrl_if.slave  strm,
  output logic         locked,
  output logic         overflow,
  output logic [7:0]   sync_err_cnt
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(FRAME_BYTES - 1);
  localparam logic [MISS_CNT_W-1:0] MISS_LIMIT = MISS_CNT_W'(LOCK_MISSES);

  state_t                state;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [MISS_CNT_W-1:0] miss_cnt;
  logic [7:0]            shift_next;
  logic                  shift_en, shift_clr, byte_done, full;
  logic                  sync_hit, hunt_hit, check_miss, lose_lock, emit;

  always_comb begin
    shift_en   = strm.enable && (state != ST_IDLE);
    sync_hit   = (shift_next == SYNC_WORD);
    hunt_hit   = (state == ST_HUNT) && shift_en && (full || byte_done) && sync_hit;
    check_miss = (state == ST_CHECK) && byte_done && !sync_hit;
    lose_lock  = check_miss && ((miss_cnt + MISS_CNT_W'(1)) == MISS_LIMIT);
    emit       = (state == ST_PAYLOAD) && byte_done;
    shift_clr  = !stop && (((state == ST_IDLE) && start) || hunt_hit || lose_lock);
  end

  des40_ctrl_shift u_shift (
    .clock_40   (clock_40),
    .reset_n    (reset_n),
    .clear      (shift_clr),
    .shift_en   (shift_en),
    .data_in    (strm.data_in),
    .shift_next (shift_next),
    .byte_done  (byte_done),
    .full       (full)
  );

  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      byte_cnt         <= '0;
      miss_cnt         <= '0;
      locked           <= 1'b0;
      overflow         <= 1'b0;
      strm.byte_out    <= '0;
      strm.byte_valid  <= 1'b0;
      strm.frame_start <= 1'b0;
      strm.frame_end   <= 1'b0;
    end else if (stop) begin
      state           <= ST_IDLE;
      locked          <= 1'b0;
      strm.byte_valid <= 1'b0;
    end else begin
      if (start) overflow <= 1'b0;
      if (strm.byte_valid && strm.byte_ready) strm.byte_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HUNT;
            miss_cnt <= '0;
          end
        end
        ST_HUNT: begin
          if (hunt_hit) begin
            state    <= ST_PAYLOAD;
            byte_cnt <= '0;
            locked   <= 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (emit) begin
            // A completing byte only lands if the output slot is empty or draining this cycle.
            if (!strm.byte_valid || strm.byte_ready) begin
              strm.byte_out    <= shift_next;
              strm.byte_valid  <= 1'b1;
              strm.frame_start <= (byte_cnt == '0);
              strm.frame_end   <= (byte_cnt == LAST_BYTE);
            end else begin
              overflow <= 1'b1;
            end
            if (byte_cnt == LAST_BYTE) begin
              state    <= ST_CHECK;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (byte_done) begin
            if (sync_hit) begin
              miss_cnt <= '0;
              state    <= ST_PAYLOAD;
            end else if (lose_lock) begin
              miss_cnt <= '0;
              locked   <= 1'b0;
              state    <= ST_HUNT;
            end else begin
              miss_cnt <= miss_cnt + MISS_CNT_W'(1);
              state    <= ST_PAYLOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DES40_CTRL_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (check_miss && !stop) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

  assign sync_err_cnt = err_cnt;
`else
  assign sync_err_cnt = 8'h00;
`endif

endmodule
